regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter.
// After reset or a clear request, every architectural register is written with
// zero, one index per cycle. After that, NREQ requesters compete round-robin
// for the single write port, one accepted write per cycle.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 3,
  parameter int NREG = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_req,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_write_enable,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_write_data,
  output logic [1:0]           grant_id,
  output logic                 init_done
);

  localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] S_INIT   = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;
  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  logic [0:0]      state_q, state_d;
  logic [4:0]      clr_cnt_q, clr_cnt_d;
  // Set once index NREG-1 has been written; the following edge leaves INIT.
  logic            clr_last_q, clr_last_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            done_q;

  // Per-requester views of the flat request buses.
  logic [NREQ-1:0][4:0]      rd_lane;
  logic [NREQ-1:0][XLEN-1:0] data_lane;
  assign rd_lane   = req_rd;
  assign data_lane = req_data;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [PW-1:0]   idx;

  // Round-robin pick: scan from rr_ptr+1 upward (wrapping), first valid wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    if (state_q == S_RUN) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = PW'((int'(rr_ptr_q) + k) % NREQ);
        if (!gnt_any && req_valid[idx]) begin
          gnt_any  = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
        end
      end
    end
  end

  assign req_ready = gnt;

  // Next state: clear sweep in INIT, registered write-back of the winner in RUN.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    clr_last_d = clr_last_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    we_d       = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    if (state_q == S_INIT) begin
      if (clr_last_q) begin
        state_d    = S_RUN;
        clr_last_d = 1'b0;
        clr_cnt_d  = '0;
      end else begin
        we_d       = 1'b1;
        rd_d       = clr_cnt_q;
        data_d     = '0;
        clr_last_d = (clr_cnt_q == LAST_IDX);
        clr_cnt_d  = (clr_cnt_q == LAST_IDX) ? 5'd0 : clr_cnt_q + 5'd1;
      end
    end else begin
      if (gnt_any) begin
        // x0 writes are accepted and advance fairness but never hit the file.
        we_d       = (rd_lane[gnt_idx] != 5'd0);
        rd_d       = rd_lane[gnt_idx];
        data_d     = data_lane[gnt_idx];
        rr_ptr_d   = gnt_idx;
        grant_id_d = 2'(gnt_idx);
      end
      // A same-cycle transfer is still registered above before clearing begins.
      if (clear_req) state_d = S_INIT;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INIT;
      clr_cnt_q  <= '0;
      clr_last_q <= 1'b0;
      rr_ptr_q   <= PW'(NREQ - 1);
      grant_id_q <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      clr_last_q <= clr_last_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      done_q     <= (state_d == S_RUN);
    end
  end

  assign rf_write_enable = we_q;
  assign rf_rd           = rd_q;
  assign rf_write_data   = data_q;
  assign grant_id        = grant_id_q;
  assign init_done       = done_q;

endmodule
